// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: round-robin arbiter between I$ refills and D$ accesses
// onto a single memory port, one transaction outstanding at a time.
module l1_mem_arbiter #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        ic_req_i,
  input  logic [31:0] ic_addr_i,
  output logic        ic_gnt_o,
  output logic        ic_rvalid_o,
  output logic        ic_rlast_o,
  output logic [31:0] ic_rdata_o,
  input  logic        dc_req_i,
  input  logic        dc_we_i,
  input  logic [31:0] dc_addr_i,
  input  logic [31:0] dc_wdata_i,
  output logic        dc_gnt_o,
  output logic        dc_rvalid_o,
  output logic        dc_rlast_o,
  output logic [31:0] dc_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q;
  logic               last_owner_q;
  logic               we_q;
  logic               discard_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               ic_elig;
  logic               dc_elig;
  logic               sel_valid;
  logic               sel_owner;
  logic               last_beat;
  logic               ic_cancel;

  // Round-robin pick; a flushing I$ is not eligible this cycle
  always_comb begin
    ic_elig   = ic_req_i & ~flush_i;
    dc_elig   = dc_req_i;
    sel_valid = ic_elig | dc_elig;
    if (ic_elig && dc_elig) begin
      sel_owner = (last_owner_q == OWN_IC) ? OWN_DC : OWN_IC;
    end else begin
      sel_owner = dc_elig ? OWN_DC : OWN_IC;
    end
  end

  // A write completes on its first beat; a read on beat BURST_LEN-1
  assign last_beat = we_q | (cnt_q == CNT_W'(BURST_LEN - 1));

  // I$-facing pulses are hidden once the I$ transaction is flushed
  assign ic_cancel = (owner_q == OWN_IC) & (discard_q | flush_i);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_valid) state_d = REQ;
      REQ:     if (mem_gnt_i) state_d = DATA;
      DATA:    if (mem_rvalid_i && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction context: owner, request fields, beat count, discard
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q      <= OWN_IC;
      last_owner_q <= OWN_IC;
      we_q         <= 1'b0;
      discard_q    <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
          if (sel_valid) begin
            owner_q      <= sel_owner;
            last_owner_q <= sel_owner;
            cnt_q        <= '0;
            if (sel_owner == OWN_DC) begin
              we_q    <= dc_we_i;
              addr_q  <= dc_addr_i;
              wdata_q <= dc_wdata_i;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= ic_addr_i;
              wdata_q <= 32'd0;
            end
          end
        end
        REQ: begin
          if (flush_i && owner_q == OWN_IC) discard_q <= 1'b1;
        end
        DATA: begin
          if (flush_i && owner_q == OWN_IC) discard_q <= 1'b1;
          if (mem_rvalid_i && !we_q) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: begin
          discard_q <= 1'b0;
        end
      endcase
    end
  end

  // Output decode: memory request from state, responses passed through
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    ic_gnt_o    = 1'b0;
    ic_rvalid_o = 1'b0;
    ic_rlast_o  = 1'b0;
    ic_rdata_o  = 32'd0;
    dc_gnt_o    = 1'b0;
    dc_rvalid_o = 1'b0;
    dc_rlast_o  = 1'b0;
    dc_rdata_o  = 32'd0;
    case (state_q)
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_gnt_i) begin
          dc_gnt_o = (owner_q == OWN_DC);
          ic_gnt_o = (owner_q == OWN_IC) & ~ic_cancel;
        end
      end
      DATA: begin
        if (mem_rvalid_i) begin
          if (owner_q == OWN_DC) begin
            dc_rvalid_o = 1'b1;
            dc_rlast_o  = last_beat;
            dc_rdata_o  = we_q ? 32'd0 : mem_rdata_i;
          end else if (!ic_cancel) begin
            ic_rvalid_o = 1'b1;
            ic_rlast_o  = last_beat;
            ic_rdata_o  = mem_rdata_i;
          end
        end
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

endmodule
